// File: rtl/reg_bank_pkg.sv
// reg_bank_pkg
// Shared defaults and typedefs for the register bank with busy scoreboard.
//   DATA_W_DEF / ADDR_W_DEF : default data and address widths
//   reg_data_t / reg_addr_t : data and address types at the default widths
package reg_bank_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 4;

    typedef logic [DATA_W_DEF-1:0] reg_data_t;
    typedef logic [ADDR_W_DEF-1:0] reg_addr_t;

endpackage

// File: rtl/rb_scoreboard.sv
// rb_scoreboard
// Per-register busy tracking between issue and write-back.
//   clk, rst            : clock, asynchronous active-high reset
//   iss_valid, iss_dest : issue request and the destination it reserves
//   iss_ready           : issue can be accepted (destination not busy)
//   wb_valid, wb_dest   : write-back strobe and register
//   busy_vec            : registered busy bit per register
//   busy_count          : registered number of busy registers
//   wb_err              : sticky flag, a write-back hit a non-busy register
module rb_scoreboard
    import reg_bank_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter bit ZERO_REG = 1'b0,
    localparam int DEPTH   = 2**ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              iss_valid,
    input  logic [ADDR_W-1:0] iss_dest,
    input  logic              wb_valid,
    input  logic [ADDR_W-1:0] wb_dest,
    output logic [DEPTH-1:0]  busy_vec,
    output logic [ADDR_W:0]   busy_count,
    output logic              iss_ready,
    output logic              wb_err
);

    logic             iss_zero;
    logic             wb_zero;
    logic             iss_set;
    logic             wb_act;
    logic             wb_clr;
    logic             wb_spur;
    logic [DEPTH-1:0] busy_nxt;
    logic [ADDR_W:0]  count_nxt;

    always_comb begin
        iss_zero  = ZERO_REG && (iss_dest == '0);
        wb_zero   = ZERO_REG && (wb_dest == '0);
        // iss_ready deliberately ignores a same-cycle write-back: WAW stalls
        // until the busy bit has actually been cleared.
        iss_ready = iss_zero || !busy_vec[iss_dest];
        iss_set   = iss_valid && iss_ready && !iss_zero;
        wb_act    = wb_valid && !wb_zero;
        wb_clr    = wb_act && busy_vec[wb_dest];
        wb_spur   = wb_act && !busy_vec[wb_dest];

        // Issue is applied after write-back so that, on the same register,
        // the busy-set wins over the clear.
        busy_nxt = busy_vec;
        if (wb_act)
            busy_nxt[wb_dest] = 1'b0;
        if (iss_set)
            busy_nxt[iss_dest] = 1'b1;

        // wb_clr implies at least one busy bit, so the counter never underflows;
        // iss_set implies a free register, so it never exceeds DEPTH.
        count_nxt = busy_count + {{ADDR_W{1'b0}}, iss_set} - {{ADDR_W{1'b0}}, wb_clr};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_vec   <= '0;
            busy_count <= '0;
            wb_err     <= 1'b0;
        end else begin
            busy_vec   <= busy_nxt;
            busy_count <= count_nxt;
            if (wb_spur)
                wb_err <= 1'b1;
        end
    end

endmodule

// File: rtl/reg_bank_sb.sv
// reg_bank_sb
// Register bank with two bypassed read ports, one write-back port and a
// per-register busy scoreboard, placed between instruction issue and the ALU.
//   clk, rst                    : clock, asynchronous active-high reset
//   rd_addr1/2                  : read addresses
//   rd_data1/2, rd_ready1/2     : combinational operand and its valid flag
//   iss_valid, iss_dest         : reserve a destination register
//   iss_ready                   : issue can be accepted
//   wb_valid, wb_dest, wb_data  : ALU write-back
//   busy_vec, busy_count        : registered busy state
//   wb_err                      : sticky spurious write-back flag
module reg_bank_sb
    import reg_bank_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int ZERO_REG = 0,
    localparam int DEPTH   = 2**ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    output logic              rd_ready1,
    output logic              rd_ready2,
    input  logic              iss_valid,
    input  logic [ADDR_W-1:0] iss_dest,
    output logic              iss_ready,
    input  logic              wb_valid,
    input  logic [ADDR_W-1:0] wb_dest,
    input  logic [DATA_W-1:0] wb_data,
    output logic [DEPTH-1:0]  busy_vec,
    output logic [ADDR_W:0]   busy_count,
    output logic              wb_err
);

    localparam bit ZR = (ZERO_REG != 0);

    logic [DATA_W-1:0] regs [DEPTH];
    logic              wr_en;
    logic              rd_zero1;
    logic              rd_zero2;
    logic              byp1;
    logic              byp2;

    rb_scoreboard #(
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZR)
    ) u_sb (
        .clk        (clk),
        .rst        (rst),
        .iss_valid  (iss_valid),
        .iss_dest   (iss_dest),
        .wb_valid   (wb_valid),
        .wb_dest    (wb_dest),
        .busy_vec   (busy_vec),
        .busy_count (busy_count),
        .iss_ready  (iss_ready),
        .wb_err     (wb_err)
    );

    assign wr_en = wb_valid && !(ZR && (wb_dest == '0));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++)
                regs[i] <= '0;
        end else if (wr_en) begin
            regs[wb_dest] <= wb_data;
        end
    end

    // Read ports: a hardwired zero register overrides the bypass, the bypass
    // overrides the stored value and also makes a busy operand ready.
    always_comb begin
        rd_zero1  = ZR && (rd_addr1 == '0);
        rd_zero2  = ZR && (rd_addr2 == '0);
        byp1      = wb_valid && (wb_dest == rd_addr1) && !rd_zero1;
        byp2      = wb_valid && (wb_dest == rd_addr2) && !rd_zero2;
        rd_data1  = rd_zero1 ? '0 : (byp1 ? wb_data : regs[rd_addr1]);
        rd_data2  = rd_zero2 ? '0 : (byp2 ? wb_data : regs[rd_addr2]);
        rd_ready1 = rd_zero1 || byp1 || !busy_vec[rd_addr1];
        rd_ready2 = rd_zero2 || byp2 || !busy_vec[rd_addr2];
    end

endmodule

// File: tb/tb_reg_bank_sb.sv
// tb_reg_bank_sb
// Directed bench for reg_bank_sb. The stimulus process drives inputs just
// after each rising edge and queues the expected outputs; a monitor pops and
// compares them on the following falling edge. Two instances are used: one
// with ZERO_REG = 0 (main function) and one with ZERO_REG = 1 (register 0).
module tb_reg_bank_sb;
    import reg_bank_pkg::*;

    localparam int DEPTH = 16;

    // Output selectors for the checker; 8..15 are the ZERO_REG = 1 instance.
    localparam int S_RD1 = 0, S_RD2 = 1, S_RDY1 = 2, S_RDY2 = 3;
    localparam int S_ISSR = 4, S_BUSY = 5, S_CNT = 6, S_ERR = 7;
    localparam int Z_RD1 = 8, Z_RD2 = 9, Z_RDY1 = 10, Z_RDY2 = 11;
    localparam int Z_ISSR = 12, Z_BUSY = 13, Z_CNT = 14, Z_ERR = 15;

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] exp;
    } chk_t;

    chk_t q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    reg_addr_t        rd_addr1, rd_addr2, iss_dest, wb_dest;
    reg_data_t        rd_data1, rd_data2, wb_data;
    logic             rd_ready1, rd_ready2, iss_valid, iss_ready, wb_valid, wb_err;
    logic [DEPTH-1:0] busy_vec;
    logic [4:0]       busy_count;

    reg_addr_t        z_rd_addr1, z_rd_addr2, z_iss_dest, z_wb_dest;
    reg_data_t        z_rd_data1, z_rd_data2, z_wb_data;
    logic             z_rd_ready1, z_rd_ready2, z_iss_valid, z_iss_ready, z_wb_valid, z_wb_err;
    logic [DEPTH-1:0] z_busy_vec;
    logic [4:0]       z_busy_count;

    reg_bank_sb #(.DATA_W(16), .ADDR_W(4), .ZERO_REG(0)) u_dut (
        .clk(clk), .rst(rst),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .rd_data1(rd_data1), .rd_data2(rd_data2),
        .rd_ready1(rd_ready1), .rd_ready2(rd_ready2),
        .iss_valid(iss_valid), .iss_dest(iss_dest), .iss_ready(iss_ready),
        .wb_valid(wb_valid), .wb_dest(wb_dest), .wb_data(wb_data),
        .busy_vec(busy_vec), .busy_count(busy_count), .wb_err(wb_err)
    );

    reg_bank_sb #(.DATA_W(16), .ADDR_W(4), .ZERO_REG(1)) u_dz (
        .clk(clk), .rst(rst),
        .rd_addr1(z_rd_addr1), .rd_addr2(z_rd_addr2),
        .rd_data1(z_rd_data1), .rd_data2(z_rd_data2),
        .rd_ready1(z_rd_ready1), .rd_ready2(z_rd_ready2),
        .iss_valid(z_iss_valid), .iss_dest(z_iss_dest), .iss_ready(z_iss_ready),
        .wb_valid(z_wb_valid), .wb_dest(z_wb_dest), .wb_data(z_wb_data),
        .busy_vec(z_busy_vec), .busy_count(z_busy_count), .wb_err(z_wb_err)
    );

    function automatic logic [31:0] actual(input int sel);
        case (sel)
            S_RD1:   return {16'b0, rd_data1};
            S_RD2:   return {16'b0, rd_data2};
            S_RDY1:  return {31'b0, rd_ready1};
            S_RDY2:  return {31'b0, rd_ready2};
            S_ISSR:  return {31'b0, iss_ready};
            S_BUSY:  return {16'b0, busy_vec};
            S_CNT:   return {27'b0, busy_count};
            S_ERR:   return {31'b0, wb_err};
            Z_RD1:   return {16'b0, z_rd_data1};
            Z_RD2:   return {16'b0, z_rd_data2};
            Z_RDY1:  return {31'b0, z_rd_ready1};
            Z_RDY2:  return {31'b0, z_rd_ready2};
            Z_ISSR:  return {31'b0, z_iss_ready};
            Z_BUSY:  return {16'b0, z_busy_vec};
            Z_CNT:   return {27'b0, z_busy_count};
            Z_ERR:   return {31'b0, z_wb_err};
            default: return 32'hDEAD_DEAD;
        endcase
    endfunction

    task automatic chk(input string n, input int sel, input logic [31:0] v);
        chk_t c;
        c.name = n;
        c.sel  = sel;
        c.exp  = v;
        q.push_back(c);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: drain queued expectations, and check the counter invariant
    // busy_count == popcount(busy_vec) on both instances every cycle.
    always @(negedge clk) begin
        chk_t        c;
        logic [31:0] a;
        while (q.size() > 0) begin
            c = q.pop_front();
            a = actual(c.sel);
            vectors++;
            if (a !== c.exp) begin
                miscompares++;
                $display("FAIL %s: got %0h, expected %0h (t=%0t)", c.name, a, c.exp, $time);
            end
        end
        vectors++;
        if (busy_count !== 5'($countones(busy_vec))) begin
            miscompares++;
            $display("FAIL popcount: busy_count %0d, expected %0d", busy_count, $countones(busy_vec));
        end
        vectors++;
        if (z_busy_count !== 5'($countones(z_busy_vec))) begin
            miscompares++;
            $display("FAIL z_popcount: busy_count %0d, expected %0d", z_busy_count, $countones(z_busy_vec));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        rd_addr1 = '0; rd_addr2 = '0; iss_valid = 1'b0; iss_dest = '0;
        wb_valid = 1'b0; wb_dest = '0; wb_data = '0;
        z_rd_addr1 = '0; z_rd_addr2 = '0; z_iss_valid = 1'b0; z_iss_dest = '0;
        z_wb_valid = 1'b0; z_wb_dest = '0; z_wb_data = '0;
        repeat (3) @(posedge clk);
        #1;

        // Reset then read
        rst = 1'b0; rd_addr1 = 4'd3; rd_addr2 = 4'd7;
        chk("rst_rd1", S_RD1, 0);  chk("rst_rd2", S_RD2, 0);
        chk("rst_rdy1", S_RDY1, 1); chk("rst_rdy2", S_RDY2, 1);
        chk("rst_cnt", S_CNT, 0);   chk("rst_busy", S_BUSY, 0);
        chk("rst_err", S_ERR, 0);   chk("rst_issr", S_ISSR, 1);

        // Issue r5, write back BEEF two cycles later
        step(); iss_valid = 1'b1; iss_dest = 4'd5; rd_addr1 = 4'd5;
        chk("i5_issr", S_ISSR, 1); chk("i5_rdy_pre", S_RDY1, 1);
        step(); iss_valid = 1'b0;
        chk("i5_busy", S_BUSY, 32'h0020); chk("i5_cnt", S_CNT, 1); chk("i5_rdy", S_RDY1, 0);
        step();
        chk("i5_pend_rdy", S_RDY1, 0); chk("i5_pend_rd", S_RD1, 0);
        step(); wb_valid = 1'b1; wb_dest = 4'd5; wb_data = 16'hBEEF; rd_addr2 = 4'd5;
        chk("wb5_byp1", S_RD1, 32'hBEEF); chk("wb5_rdy1", S_RDY1, 1);
        chk("wb5_byp2", S_RD2, 32'hBEEF); chk("wb5_busy", S_BUSY, 32'h0020);
        step(); wb_valid = 1'b0;
        chk("wb5_st", S_RD1, 32'hBEEF); chk("wb5_rdy", S_RDY1, 1);
        chk("wb5_cnt", S_CNT, 0); chk("wb5_busy0", S_BUSY, 0); chk("wb5_err", S_ERR, 0);

        // WAW stall on r2; same-cycle write-back does not open iss_ready
        step(); iss_valid = 1'b1; iss_dest = 4'd2; rd_addr1 = 4'd2;
        chk("waw_i1", S_ISSR, 1);
        step();
        chk("waw_stall", S_ISSR, 0); chk("waw_busy", S_BUSY, 32'h0004); chk("waw_cnt", S_CNT, 1);
        step();
        chk("waw_hold_busy", S_BUSY, 32'h0004); chk("waw_hold_cnt", S_CNT, 1); chk("waw_hold", S_ISSR, 0);
        step(); wb_valid = 1'b1; wb_dest = 4'd2; wb_data = 16'h0011;
        chk("waw_wb_issr", S_ISSR, 0); chk("waw_wb_byp", S_RD1, 32'h0011); chk("waw_wb_rdy", S_RDY1, 1);
        step(); wb_valid = 1'b0;
        chk("waw_open", S_ISSR, 1); chk("waw_busy0", S_BUSY, 0); chk("waw_cnt0", S_CNT, 0);
        chk("waw_st", S_RD1, 32'h0011);
        step(); iss_valid = 1'b0;
        chk("waw_acc", S_BUSY, 32'h0004); chk("waw_acc_cnt", S_CNT, 1);

        // Parallel issue r1 and write-back of busy r4
        step(); iss_valid = 1'b1; iss_dest = 4'd4;
        chk("par_i4", S_ISSR, 1);
        step(); iss_dest = 4'd1; wb_valid = 1'b1; wb_dest = 4'd4; wb_data = 16'h4444;
        chk("par_issr", S_ISSR, 1); chk("par_busy_pre", S_BUSY, 32'h0014); chk("par_cnt_pre", S_CNT, 2);
        step(); iss_valid = 1'b0; wb_valid = 1'b0; rd_addr1 = 4'd4;
        chk("par_busy", S_BUSY, 32'h0006); chk("par_cnt", S_CNT, 2);
        chk("par_rd4", S_RD1, 32'h4444); chk("par_rdy4", S_RDY1, 1); chk("par_err", S_ERR, 0);

        // Spurious write-back to r9 sets the sticky error
        step(); wb_valid = 1'b1; wb_dest = 4'd9; wb_data = 16'h9999;
        chk("spur_err_pre", S_ERR, 0);
        step(); wb_valid = 1'b0; rd_addr2 = 4'd9;
        chk("spur_err", S_ERR, 1); chk("spur_rd9", S_RD2, 32'h9999);
        chk("spur_rdy9", S_RDY2, 1); chk("spur_cnt", S_CNT, 2);
        step(); wb_valid = 1'b1; wb_dest = 4'd1; wb_data = 16'h0101;
        step(); wb_valid = 1'b0; rd_addr1 = 4'd1;
        chk("sticky_err", S_ERR, 1); chk("wb1_busy", S_BUSY, 32'h0004);
        chk("wb1_cnt", S_CNT, 1); chk("wb1_rd", S_RD1, 32'h0101);

        // Same register, not busy: issue and write-back together, busy-set wins
        step(); iss_valid = 1'b1; iss_dest = 4'd6; wb_valid = 1'b1; wb_dest = 4'd6;
        wb_data = 16'h6666; rd_addr2 = 4'd6;
        chk("same_issr", S_ISSR, 1); chk("same_byp", S_RD2, 32'h6666); chk("same_byp_rdy", S_RDY2, 1);
        step(); iss_valid = 1'b0; wb_valid = 1'b0;
        chk("same_busy", S_BUSY, 32'h0044); chk("same_cnt", S_CNT, 2);
        chk("same_st", S_RD2, 32'h6666); chk("same_rdy", S_RDY2, 0);

        // ZERO_REG = 1 instance: register 0 is hardwired
        step(); z_wb_valid = 1'b1; z_wb_dest = 4'd0; z_wb_data = 16'h1234; z_rd_addr1 = 4'd0;
        chk("z_nobyp", Z_RD1, 0); chk("z_rdy0", Z_RDY1, 1);
        step(); z_wb_valid = 1'b0;
        chk("z_rd0", Z_RD1, 0); chk("z_err", Z_ERR, 0);
        step(); z_iss_valid = 1'b1; z_iss_dest = 4'd0;
        chk("z_issr0", Z_ISSR, 1);
        step(); z_iss_dest = 4'd3;
        chk("z_busy0", Z_BUSY, 0); chk("z_cnt0", Z_CNT, 0);
        step(); z_iss_valid = 1'b0; z_wb_valid = 1'b1; z_wb_dest = 4'd3;
        z_wb_data = 16'h3333; z_rd_addr2 = 4'd3;
        chk("z_busy3", Z_BUSY, 32'h0008); chk("z_byp3", Z_RD2, 32'h3333); chk("z_rdy3", Z_RDY2, 1);
        step(); z_wb_valid = 1'b0;
        chk("z_busy_clr", Z_BUSY, 0); chk("z_err_end", Z_ERR, 0); chk("z_st3", Z_RD2, 32'h3333);

        // Fill every register; r2 and r6 are already busy and get rejected
        for (int i = 0; i < DEPTH; i++) begin
            step(); iss_valid = 1'b1; iss_dest = reg_addr_t'(i); rd_addr1 = 4'd5;
            chk("fill_issr", S_ISSR, (i != 2 && i != 6) ? 32'd1 : 32'd0);
        end
        step(); iss_valid = 1'b0; iss_dest = 4'd0;
        chk("full_cnt", S_CNT, 16); chk("full_busy", S_BUSY, 32'hFFFF);
        chk("full_issr0", S_ISSR, 0); chk("full_rd5", S_RD1, 32'hBEEF); chk("full_rdy5", S_RDY1, 0);
        step(); iss_dest = 4'd15;
        chk("full_issr15", S_ISSR, 0);

        // Asynchronous reset between edges
        @(posedge clk); #3;
        rst = 1'b1;
        chk("arst_busy", S_BUSY, 0); chk("arst_cnt", S_CNT, 0); chk("arst_issr", S_ISSR, 1);
        chk("arst_rdy", S_RDY1, 1); chk("arst_rd5", S_RD1, 0); chk("arst_err", S_ERR, 0);
        for (int k = 0; k < DEPTH / 2; k++) begin
            step(); rd_addr1 = reg_addr_t'(2 * k); rd_addr2 = reg_addr_t'(2 * k + 1);
            chk("arst_sweep1", S_RD1, 0); chk("arst_sweep2", S_RD2, 0);
        end
        step(); rst = 1'b0; rd_addr1 = 4'd9; rd_addr2 = 4'd2;
        chk("post_cnt", S_CNT, 0); chk("post_err", S_ERR, 0);
        chk("post_rd9", S_RD1, 0); chk("post_rd2", S_RD2, 0);

        step();
        repeat (2) @(negedge clk);
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d checks left, expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
